// File: rtl/bcd_uart_reporter_pkg.sv
// Shared constants for the BCD-to-UART reporter: ASCII codes, FSM states, default baud divisor.
package bcd_uart_reporter_pkg;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int FRAME_LEN        = 10;

  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_ONE   = 8'h31;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_QMARK = 8'h3F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  // Non-decimal nibbles print as '?' so a corrupt reading is visible on the host log.
  function automatic logic [7:0] bcd_ascii(input logic [3:0] nib);
    return (nib > 4'd9) ? CH_QMARK : (CH_ZERO | {4'h0, nib});
  endfunction

endpackage

// File: rtl/bcd_uart_reporter_uart_tx_byte.sv
// 8N1 UART byte serialiser; done is combinational in the last stop-bit cycle so a new
// load on that cycle starts the next start bit with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_active;
  logic             w_bit_end;
  logic             w_done;

  assign w_bit_end = (r_cnt == CNT_MAX);
  assign w_done    = r_active & w_bit_end & (r_bit == 4'd9);

  // r_bit: 0 = start, 1..8 = data LSB first, 9 = stop
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_cnt    <= '0;
      r_bit    <= 4'd0;
      r_active <= 1'b0;
      r_tx     <= 1'b1;
    end else if (load && (!r_active || w_done)) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_bit    <= 4'd0;
      r_shift  <= din;
      r_tx     <= 1'b0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_cnt <= '0;
        if (r_bit == 4'd9) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bit <= r_bit + 4'd1;
          if (r_bit == 4'd8) begin
            r_tx <= 1'b1;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_active;
  assign done    = w_done;

endmodule

// File: rtl/bcd_uart_reporter.sv
// Formats each 4-digit BCD voltmeter reading as "A<n>:d.ddd\r\n" and ships it over UART,
// with a one-deep pending slot (newest wins) behind the frame in flight.
module bcd_uart_reporter
  import bcd_uart_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] sample_bcd,
  input  logic [1:0]  sample_ch,
  output logic        tx,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] frames_sent
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_t      r_state;
  logic [15:0] r_frame_bcd;
  logic [1:0]  r_frame_ch;
  logic [15:0] r_pend_bcd;
  logic [1:0]  r_pend_ch;
  logic        r_pend_full;
  logic [3:0]  r_idx;
  logic        r_load;
  logic        r_overrun;
  logic [15:0] r_frames;

  logic        w_tx;
  logic        w_tx_busy;
  logic        w_done;
  logic        w_last;
  logic        w_next;
  logic        w_load;
  logic        w_to_pend;
  logic [3:0]  w_sel;
  logic [7:0]  w_byte;

  assign w_last = (r_state == S_SEND) & w_done & (r_idx == LAST_IDX);
  assign w_next = (r_state == S_SEND) & w_done & (r_idx != LAST_IDX);

  // The first byte goes out from a registered load; later bytes chain on done in the same
  // cycle so consecutive bytes are back-to-back on the line.
  assign w_load = r_load | w_next;
  assign w_sel  = r_load ? 4'd0 : (r_idx + 4'd1);

  // At frame end with an empty slot, a simultaneous sample goes straight into the frame.
  assign w_to_pend = sample_valid & (r_state != S_IDLE) & ~(w_last & ~r_pend_full);

  always_comb begin
    w_byte = CH_LF;
    case (w_sel)
      4'd0:    w_byte = CH_A;
      4'd1:    w_byte = CH_ONE + {6'd0, r_frame_ch};
      4'd2:    w_byte = CH_COLON;
      4'd3:    w_byte = bcd_ascii(r_frame_bcd[15:12]);
      4'd4:    w_byte = CH_DOT;
      4'd5:    w_byte = bcd_ascii(r_frame_bcd[11:8]);
      4'd6:    w_byte = bcd_ascii(r_frame_bcd[7:4]);
      4'd7:    w_byte = bcd_ascii(r_frame_bcd[3:0]);
      4'd8:    w_byte = CH_CR;
      default: w_byte = CH_LF;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pend_full <= 1'b0;
      r_idx       <= 4'd0;
      r_load      <= 1'b0;
      r_overrun   <= 1'b0;
      r_frames    <= 16'd0;
    end else begin
      r_load    <= 1'b0;
      r_overrun <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (sample_valid) begin
            r_frame_bcd <= sample_bcd;
            r_frame_ch  <= sample_ch;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_idx   <= 4'd0;
          r_load  <= 1'b1;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_next) begin
            r_idx <= r_idx + 4'd1;
          end else if (w_last) begin
            r_frames <= r_frames + 16'd1;
            if (r_pend_full) begin
              r_frame_bcd <= r_pend_bcd;
              r_frame_ch  <= r_pend_ch;
              r_state     <= S_LOAD;
            end else if (sample_valid) begin
              r_frame_bcd <= sample_bcd;
              r_frame_ch  <= sample_ch;
              r_state     <= S_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_to_pend) begin
        r_pend_bcd  <= sample_bcd;
        r_pend_ch   <= sample_ch;
        r_pend_full <= 1'b1;
        if (r_pend_full) begin
          r_overrun <= 1'b1;
        end
      end else if (w_last && r_pend_full) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .load      (w_load),
    .din       (w_byte),
    .tx        (w_tx),
    .tx_busy   (w_tx_busy),
    .done      (w_done)
  );

  assign tx          = w_tx;
  assign busy        = (r_state != S_IDLE) | r_pend_full | w_tx_busy;
  assign overrun     = r_overrun;
  assign frames_sent = r_frames;

endmodule

// File: tb/tb_bcd_uart_reporter.sv
// Directed bench for bcd_uart_reporter at 4 clocks/bit; a mid-bit UART monitor decodes tx.
module tb_bcd_uart_reporter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_bcd = 16'h0;
  logic [1:0]  sample_ch = 2'd0;
  logic        tx;
  logic        busy;
  logic        overrun;
  logic [15:0] frames_sent;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int framing_err = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];

  bcd_uart_reporter #(.CLKS_PER_BIT(4)) dut (
    .CLK100MHZ   (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_bcd  (sample_bcd),
    .sample_ch   (sample_ch),
    .tx          (tx),
    .busy        (busy),
    .overrun     (overrun),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  // UART monitor: 40 negedge samples per byte, each bit must hold for all 4 of its cycles
  logic [9:0] m_bits;
  logic       m_abort;
  logic       m_unstable;
  int         m_t0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        m_t0 = cyc;
        m_bits = '0;
        m_abort = 1'b0;
        m_unstable = 1'b0;
        for (int k = 0; k < 40; k++) begin
          if (k > 0) @(negedge clk);
          if (reset) begin
            m_abort = 1'b1;
            break;
          end
          if (k % 4 == 0) m_bits[k/4] = tx;
          else if (tx !== m_bits[k/4]) m_unstable = 1'b1;
        end
        if (!m_abort) begin
          rx_q.push_back(m_bits[8:1]);
          rx_t.push_back(m_t0);
          if (m_bits[0] !== 1'b0 || m_bits[9] !== 1'b1 || m_unstable) framing_err++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] b, input logic [1:0] c, output int n);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_bcd = b;
    sample_ch = c;
    @(posedge clk);
    #1;
    n = cyc;
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_frame(input string tag, input logic [79:0] exp,
                              output int t_first, output int t_last);
    logic [7:0] b;
    int t, tp;
    t_first = 0;
    t_last = 0;
    tp = 0;
    chk({tag, "_count"}, 32'(rx_q.size() >= 10), 1);
    if (rx_q.size() < 10) return;
    for (int i = 0; i < 10; i++) begin
      b = rx_q.pop_front();
      t = rx_t.pop_front();
      chk($sformatf("%s_b%0d", tag, i), b, exp[79-8*i -: 8]);
      if (i == 0) t_first = t;
      else if (i == 5 || i == 9) chk($sformatf("%s_sp%0d", tag, i), t - tp, 40);
      tp = t;
    end
    t_last = tp;
  endtask

  initial begin
    int n, n2, tf, tl, tf2, tl2;
    logic [79:0] e;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_frames", frames_sent, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: basic frame and latency
    send(16'h0512, 2'd0, n);
    chk("t1_busy_up", busy, 1'b1);
    wait_idle("t1");
    e = 80'h41313A302E3531320D0A;
    expect_frame("t1", e, tf, tl);
    chk("t1_lat", tf - n, 2);
    chk("t1_frames", frames_sent, 16'd1);
    chk("t1_tx_idle", tx, 1'b1);

    // 2: over-range and non-decimal nibbles
    send(16'h1000, 2'd3, n);
    wait_idle("t2a");
    e = 80'h41343A312E3030300D0A;
    expect_frame("t2a", e, tf, tl);
    send(16'h0A0F, 2'd0, n);
    wait_idle("t2b");
    e = 80'h41313A302E3F303F0D0A;
    expect_frame("t2b", e, tf, tl);
    chk("t2_frames", frames_sent, 16'd3);

    // 3: X in flight, Y then Z queued; Z overwrites Y
    send(16'h1234, 2'd1, n);
    repeat (50) @(posedge clk);
    send(16'h0001, 2'd2, n2);
    chk("t3_ovr_y", overrun, 1'b0);
    repeat (20) @(posedge clk);
    send(16'h9876, 2'd3, n2);
    chk("t3_ovr_z", overrun, 1'b1);
    @(posedge clk);
    #1;
    chk("t3_ovr_1cyc", overrun, 1'b0);
    wait_idle("t3");
    e = 80'h41323A312E3233340D0A;
    expect_frame("t3x", e, tf, tl);
    e = 80'h41343A392E3837360D0A;
    expect_frame("t3z", e, tf2, tl2);
    chk("t3_gap", tf2 - tl, 42);
    chk("t3_leftover", rx_q.size(), 0);
    chk("t3_ovr_cnt", ovr_cnt, 1);
    chk("t3_frames", frames_sent, 16'd5);

    // 4: valid on the same edge as the final done of X
    send(16'h0000, 2'd0, n);
    repeat (401) @(posedge clk);
    send(16'h0999, 2'd2, n2);
    chk("t4_edge", n2 - n, 402);
    chk("t4_ovr", overrun, 1'b0);
    chk("t4_busy", busy, 1'b1);
    chk("t4_frames_x", frames_sent, 16'd6);
    wait_idle("t4");
    e = 80'h41313A302E3030300D0A;
    expect_frame("t4x", e, tf, tl);
    e = 80'h41333A302E3939390D0A;
    expect_frame("t4w", e, tf2, tl2);
    chk("t4_gap", tf2 - tl, 42);
    chk("t4_ovr_cnt", ovr_cnt, 1);
    chk("t4_frames", frames_sent, 16'd7);

    // 5: reset during byte 4
    send(16'h0777, 2'd0, n);
    repeat (170) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_tx", tx, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_frames", frames_sent, 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (500) @(negedge clk);
    chk("t5_nbytes", rx_q.size(), 4);
    if (rx_q.size() == 4) begin
      chk("t5_b0", rx_q.pop_front(), 8'h41);
      chk("t5_b1", rx_q.pop_front(), 8'h31);
      chk("t5_b2", rx_q.pop_front(), 8'h3A);
      chk("t5_b3", rx_q.pop_front(), 8'h30);
    end
    rx_q.delete();
    rx_t.delete();
    chk("t5_busy_after", busy, 1'b0);
    chk("t5_frames_after", frames_sent, 16'h0);

    // 6: frame counter wrap, bit timing
    @(negedge clk);
    force dut.r_frames = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.r_frames;
    send(16'h0345, 2'd1, n);
    wait_idle("t6");
    e = 80'h41323A302E3334350D0A;
    expect_frame("t6", e, tf, tl);
    chk("t6_frame_len", tl - tf, 360);
    chk("t6_wrap", frames_sent, 16'h0);

    chk("framing", framing_err, 0);
    chk("end_ovr_cnt", ovr_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
